// File: rtl/ram_arbiter.sv
// Fetch / load-store arbiter and sequencer for the shared single-port data RAM.
// ARB_ROUND_ROBIN_EN: alternate grants on ties (default: data port wins ties).
module ram_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_u_b_h_w,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       lat_we;
  logic       grant_d;

  a_latency: assert property (
    @(posedge clk) disable iff (rst)
    (LATENCY >= 1 && LATENCY <= 15)
  );

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = d_req && (!if_req || !owner);
`else
    grant_d = d_req;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      owner       <= 1'b1;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      ram_u_b_h_w <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner       <= grant_d;
            lat_we      <= grant_d && d_we;
            ram_addr    <= grant_d ? d_addr : if_addr;
            ram_din     <= grant_d ? d_wdata : '0;
            ram_u_b_h_w <= grant_d ? d_u_b_h_w : 3'b010;
            cnt         <= CNT_INIT;
            // single-cycle access: the only ACCESS cycle is the strobe cycle
            ram_we      <= (CNT_INIT == 4'd0) && grant_d && d_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_we) begin
              if (owner) d_rdata <= ram_dout;
              else       if_rdata <= ram_dout;
            end
            if_ack <= !owner;
            d_ack  <= owner;
            state  <= DONE;
          end else begin
            cnt    <= cnt - 4'd1;
            ram_we <= (cnt == 4'd1) && lat_we;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model.
// Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_u_b_h_w = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [2:0]  ram_u_b_h_w;
  logic [31:0] ram_dout;
  logic        busy;
  logic        owner;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int ifa_cnt = 0;
  int da_cnt = 0;

  logic [7:0]  mem [0:255];
  logic [7:0]  ra;
  logic [31:0] rw;

  always #5 clk = ~clk;

  ram_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_u_b_h_w(d_u_b_h_w),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_u_b_h_w(ram_u_b_h_w),
    .ram_dout(ram_dout), .busy(busy), .owner(owner)
  );

  always_comb begin
    ra = ram_addr[7:0];
    rw = {mem[ra+8'd3], mem[ra+8'd2], mem[ra+8'd1], mem[ra]};
    if (ram_u_b_h_w[1])
      ram_dout = rw;
    else if (ram_u_b_h_w[0])
      ram_dout = ram_u_b_h_w[2] ? {16'h0, rw[15:0]}
                                : {{16{rw[15]}}, rw[15:0]};
    else
      ram_dout = ram_u_b_h_w[2] ? {24'h0, rw[7:0]}
                                : {{24{rw[7]}}, rw[7:0]};
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_din[7:0];
      if (ram_u_b_h_w[1] || ram_u_b_h_w[0])
        mem[ram_addr[7:0]+8'd1] <= ram_din[15:8];
      if (ram_u_b_h_w[1]) begin
        mem[ram_addr[7:0]+8'd2] <= ram_din[23:16];
        mem[ram_addr[7:0]+8'd3] <= ram_din[31:24];
      end
      we_cnt <= we_cnt + 1;
    end
    if (if_ack) ifa_cnt <= ifa_cnt + 1;
    if (d_ack)  da_cnt  <= da_cnt + 1;
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  w;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int we0;
    bit got;
    @(negedge clk);
    we0 = we_cnt;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr;
      d_wdata = v.wdata; d_u_b_h_w = v.w;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (n <= LAT) begin
        chk("busy", busy, 1'b1);
        chk("ram_addr", ram_addr, v.addr);
        chk("ram_width", ram_u_b_h_w, v.is_d ? v.w : 3'b010);
        chk("ram_we", ram_we, (n == LAT) && v.is_d && v.we);
      end
      if (if_ack || d_ack) got = 1'b1;
    end
    chk("ack_time", n, LAT + 1);
    chk("ack_port", {if_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
    chk("owner", owner, v.is_d);
    chk("if_rdata", if_rdata, v.exp_if);
    chk("d_rdata", d_rdata, v.exp_d);
    chk("we_pulses", we_cnt - we0, (v.is_d && v.we) ? 1 : 0);
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic run_tie(input int ntx, input bit hold);
    int n;
    int k;
    int last;
    int ifa0;
    bit eo;
    do_reset();
    @(negedge clk);
    ifa0 = ifa_cnt;
    if_addr = 32'h10;
    d_we = 1'b0; d_addr = 32'h20; d_u_b_h_w = 3'b010;
    if_req = 1'b1;
    d_req = 1'b1;
    n = 0; k = 0; last = 0;
    while (k < ntx && n < ntx * (LAT + 2) + 20) begin
      @(negedge clk);
      n++;
      if (if_ack || d_ack) begin
`ifdef ARB_ROUND_ROBIN_EN
        eo = (k % 2 == 1);
`else
        eo = hold ? 1'b1 : (k == 0);
`endif
        chk("tie_owner", owner, eo);
        chk("tie_dack", d_ack, eo);
        if (k > 0) chk("tie_spacing", n - last, LAT + 2);
        else       chk("tie_first", n, LAT + 1);
        last = n;
        k++;
        if (!hold) begin
          if (if_ack) if_req = 1'b0;
          if (d_ack)  d_req = 1'b0;
        end
      end
    end
    chk("tie_count", k, ntx);
    if (hold) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_if_acks", ifa_cnt - ifa0, ntx / 2);
`else
      chk("tie_if_acks", ifa_cnt - ifa0, 0);
`endif
    end
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_rst_store();
    int n;
    int we0;
    int da0;
    do_reset();
    @(negedge clk);
    we0 = we_cnt;
    da0 = da_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50;
    d_wdata = 32'hCAFEF00D; d_u_b_h_w = 3'b010;
    for (int i = 0; i < LAT; i++) @(negedge clk);
    chk("rs_we_before", ram_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rs_we_async", ram_we, 1'b0);
    chk("rs_busy", busy, 1'b0);
    #1 rst = 1'b0;
    n = 0;
    while (!d_ack && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("rs_mem_kept", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]},
            32'h0);
        chk("rs_no_ack", da_cnt - da0, 0);
        chk("rs_no_we", we_cnt - we0, 0);
      end
    end
    chk("rs_ack_time", n, LAT + 1);
    d_req = 1'b0;
    @(negedge clk);
    chk("rs_mem_new", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]},
        32'hCAFEF00D);
    chk("rs_we_once", we_cnt - we0, 1);
    chk("rs_ack_once", da_cnt - da0, 1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h10, 32'h00500093, 3'b010, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h30, 32'h00000080, 3'b000, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h50, 32'h00000000, 3'b010, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h00500093, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 3'b010,
                 32'h00500093, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h20, 32'h0, 3'b010,
                 32'h00500093, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h30, 32'h0, 3'b000,
                 32'h00500093, 32'hFFFFFF80};
    vecs[7]  = '{1'b1, 1'b1, 32'h34, 32'h12345678, 3'b010,
                 32'h00500093, 32'hFFFFFF80};
    vecs[8]  = '{1'b1, 1'b0, 32'h22, 32'h0, 3'b101,
                 32'h00500093, 32'h0000DEAD};
    vecs[9]  = '{1'b0, 1'b0, 32'h34, 32'h0, 3'b010,
                 32'h12345678, 32'h0000DEAD};
    vecs[10] = '{1'b1, 1'b0, 32'h20, 32'h0, 3'b001,
                 32'h12345678, 32'hFFFFBEEF};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_width", ram_u_b_h_w, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    run_tie(2, 1'b0);
    run_tie(8, 1'b1);
    run_rst_store();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
